// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: synchronizer, per-key debounce FSM, registered press/release pulses.
// Define KEY_AUTOREPEAT_EN to add auto-repeat pressed pulses while a key stays held.
module key_conditioner #(
  parameter int N_KEYS       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic              clkSelect,
  input  logic              RST,
  input  logic [N_KEYS-1:0] key_n,
  input  logic              en,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] released,
  output logic [N_KEYS-1:0] held,
  output logic              any_held
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  if (N_KEYS < 1 || N_KEYS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DB_CYCLES < 1 || DB_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_badParams
    $error("key_conditioner: parameter out of range");
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);
`endif

  logic [N_KEYS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [N_KEYS-1:0] s;
  logic [N_KEYS-1:0] pressed_d, released_d, held_d;
  logic [N_KEYS-1:0] pressed_q, released_q, held_q;
  logic              anyHeld_q;

  // Inverted so that a 1 in the chain always means "pressed"; reset reads as released.
  always_ff @(posedge clkSelect) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], ~key_n[k]};
      end
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressEv, relEv, repEv;

    assign s[k] = sync_q[k][SYNC_STAGES-1];

    always_ff @(posedge clkSelect) begin
      if (RST) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pressEv = 1'b0;
      relEv   = 1'b0;
      case (state_q)
        IDLE: begin
          if (s[k]) begin
            state_d = DB_PRESS;
            cnt_d   = CW'(1);
          end
        end
        DB_PRESS: begin
          if (!s[k]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DB_CYCLES)) begin
            state_d = HELD;
            cnt_d   = '0;
            pressEv = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!s[k]) begin
            state_d = DB_RELEASE;
            cnt_d   = CW'(1);
          end
        end
        DB_RELEASE: begin
          if (s[k]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DB_CYCLES)) begin
            state_d = IDLE;
            cnt_d   = '0;
            relEv   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
    logic          repFirst_q, repFirst_d;

    always_ff @(posedge clkSelect) begin
      if (RST) begin
        rep_q      <= '0;
        repFirst_q <= 1'b1;
      end else begin
        rep_q      <= rep_d;
        repFirst_q <= repFirst_d;
      end
    end

    // Counts only while staying in HELD, so DB_RELEASE and the exit edge freeze it.
    always_comb begin
      rep_d      = rep_q;
      repFirst_d = repFirst_q;
      repEv      = 1'b0;
      if (pressEv) begin
        rep_d      = '0;
        repFirst_d = 1'b1;
      end else if (state_q == HELD && s[k]) begin
        if (rep_q + RW'(1) == (repFirst_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE))) begin
          repEv      = 1'b1;
          rep_d      = '0;
          repFirst_d = 1'b0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
    end
`else
    assign repEv = 1'b0;
`endif

    assign pressed_d[k]  = en & (pressEv | repEv);
    assign released_d[k] = en & relEv;
    assign held_d[k]     = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clkSelect) begin
    if (RST) begin
      pressed_q  <= '0;
      released_q <= '0;
      held_q     <= '0;
      anyHeld_q  <= 1'b0;
    end else begin
      pressed_q  <= pressed_d;
      released_q <= released_d;
      held_q     <= held_d;
      anyHeld_q  <= |held_d;
    end
  end

  assign pressed  = pressed_q;
  assign released = released_q;
  assign held     = held_q;
  assign any_held = anyHeld_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed key waveforms push expected pulses, a monitor checks them.
// Expected auto-repeat pulses are added when KEY_AUTOREPEAT_EN is defined.
module tb_key_conditioner;

  localparam int NK     = 3;
  localparam int RDELAY = 8;
  localparam int RRATE  = 4;
  localparam int LAT    = 7;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
  } exp_t;

  logic          clkSelect = 1'b0;
  logic          RST;
  logic [NK-1:0] key_n;
  logic          en;
  logic [NK-1:0] pressed, released, held;
  logic          any_held;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  key_conditioner #(
    .N_KEYS(NK), .SYNC_STAGES(2), .DB_CYCLES(4),
    .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .clkSelect(clkSelect), .RST(RST), .key_n(key_n), .en(en),
    .pressed(pressed), .released(released), .held(held), .any_held(any_held)
  );

  always #5 clkSelect = ~clkSelect;

  always @(posedge clkSelect) cyc <= cyc + 1;

  // Keeps the queue sorted by cycle, merging events that land on the same cycle.
  task automatic pushExp(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r);
    exp_t e;
    int   idx;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc == c) begin
        e = expQ[i];
        e.p = e.p | p;
        e.r = e.r | r;
        expQ[i] = e;
        return;
      end
      if (expQ[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    expQ.insert(idx, e);
  endtask

  task automatic pushRepeats(input logic [NK-1:0] m, input int acc, input int lastHeld);
    int t;
    int step;
    t = acc + RDELAY;
    step = RRATE;
    if (AUTOREP) begin
      while (t <= lastHeld) begin
        pushExp(t, m, '0);
        t += step;
      end
    end
  endtask

  task automatic tickTo(input int c);
    while (cyc < c) @(negedge clkSelect);
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k, input logic e, input logic r);
    key_n = k;
    en    = e;
    RST   = r;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: any pulse on pressed/released must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkSelect);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missedPulse: expected pressed=%b released=%b at cycle %0d, saw none",
                 e.p, e.r, e.cyc);
      end
      if (pressed !== '0 || released !== '0) begin
        checks++;
        if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
          errors++;
          $display("[TB] FAIL unexpectedPulse at cycle %0d: pressed=%b released=%b, expected none",
                   cyc, pressed, released);
        end else begin
          e = expQ.pop_front();
          if (pressed !== e.p || released !== e.r) begin
            errors++;
            $display("[TB] FAIL pulseValue at cycle %0d: pressed=%b released=%b, expected pressed=%b released=%b",
                     cyc, pressed, released, e.p, e.r);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(3'b000, 1'b1, 1'b1);

    // Reset with all keys down, then all three accepted together.
    tickTo(1);
    checkOutput("resetOutputs1", {pressed, released, held, any_held}, 16'h0);
    tickTo(2);
    checkOutput("resetOutputs2", {pressed, released, held, any_held}, 16'h0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    pushExp(2 + LAT, 3'b111, 3'b000);
    pushRepeats(3'b111, 2 + LAT, 22);
    tickTo(8);
    checkOutput("heldBeforeAccept", {held, any_held}, 16'h0);
    tickTo(12);
    checkOutput("allHeld", {held, any_held}, 16'hF);
    tickTo(20);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(20 + LAT, 3'b000, 3'b111);
    tickTo(26);
    checkOutput("heldDuringReleaseDb", {held, any_held}, 16'hF);
    tickTo(28);
    checkOutput("allReleased", {held, any_held}, 16'h0);

    // Single press of key 0 held for 20 cycles.
    tickTo(35);
    applyStimulus(3'b110, 1'b1, 1'b0);
    pushExp(35 + LAT, 3'b001, 3'b000);
    pushRepeats(3'b001, 35 + LAT, 57);
    tickTo(45);
    checkOutput("key0Held", {held, any_held}, 16'h3);
    tickTo(55);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(55 + LAT, 3'b000, 3'b001);
    tickTo(63);
    checkOutput("key0Released", {held, any_held}, 16'h0);

    // Bouncing key 1: only the steady low from cycle 78 is accepted.
    tickTo(70); applyStimulus(3'b101, 1'b1, 1'b0);
    tickTo(73); applyStimulus(3'b111, 1'b1, 1'b0);
    tickTo(74); applyStimulus(3'b101, 1'b1, 1'b0);
    tickTo(77); applyStimulus(3'b111, 1'b1, 1'b0);
    tickTo(78); applyStimulus(3'b101, 1'b1, 1'b0);
    pushExp(78 + LAT, 3'b010, 3'b000);
    pushRepeats(3'b010, 78 + LAT, 97);
    tickTo(84);
    checkOutput("bounceNotYetHeld", {held, any_held}, 16'h0);
    tickTo(86);
    checkOutput("bounceHeld", {held, any_held}, 16'h5);
    tickTo(95);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(95 + LAT, 3'b000, 3'b010);

    // Key 2 release glitch of two cycles must not drop held.
    tickTo(110);
    applyStimulus(3'b011, 1'b1, 1'b0);
    pushExp(110 + LAT, 3'b100, 3'b000);
    tickTo(118); applyStimulus(3'b111, 1'b1, 1'b0);
    tickTo(120); applyStimulus(3'b011, 1'b1, 1'b0);
    tickTo(122);
    checkOutput("releaseGlitchHeld", {held, any_held}, 16'h9);
    tickTo(124);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(124 + LAT, 3'b000, 3'b100);
    tickTo(125);
    checkOutput("releaseGlitchStillHeld", {held, any_held}, 16'h9);
    tickTo(132);
    checkOutput("key2Released", {held, any_held}, 16'h0);

    // Keys 0 and 2 together, en low at the accepting edge: no pressed pulse.
    tickTo(140); applyStimulus(3'b010, 1'b1, 1'b0);
    tickTo(146); applyStimulus(3'b010, 1'b0, 1'b0);
    tickTo(147); applyStimulus(3'b010, 1'b1, 1'b0);
    pushRepeats(3'b101, 147, 152);
    tickTo(148);
    checkOutput("enGatedHeld", {held, any_held}, 16'hB);
    tickTo(150);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(150 + LAT, 3'b000, 3'b101);
    tickTo(158);
    checkOutput("enGatedReleased", {held, any_held}, 16'h0);

    // Reset while key 0 is held; debounce restarts once reset drops.
    tickTo(170);
    applyStimulus(3'b110, 1'b1, 1'b0);
    pushExp(170 + LAT, 3'b001, 3'b000);
    tickTo(179);
    checkOutput("preResetHeld", {held, any_held}, 16'h3);
    tickTo(180);
    applyStimulus(3'b110, 1'b1, 1'b1);
    tickTo(181);
    checkOutput("midPressReset", {pressed, released, held, any_held}, 16'h0);
    applyStimulus(3'b110, 1'b1, 1'b0);
    pushExp(181 + LAT, 3'b001, 3'b000);
    pushRepeats(3'b001, 181 + LAT, 195);
    tickTo(193);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(193 + LAT, 3'b000, 3'b001);
    tickTo(201);
    checkOutput("postResetReleased", {held, any_held}, 16'h0);

    // Long hold of key 1 for 30 cycles (auto-repeat window).
    tickTo(210);
    applyStimulus(3'b101, 1'b1, 1'b0);
    pushExp(210 + LAT, 3'b010, 3'b000);
    pushRepeats(3'b010, 210 + LAT, 242);
    tickTo(240);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(240 + LAT, 3'b000, 3'b010);
    tickTo(248);
    checkOutput("longHoldReleased", {held, any_held}, 16'h0);

    // Four low samples are rejected, five are accepted.
    tickTo(260); applyStimulus(3'b110, 1'b1, 1'b0);
    tickTo(264); applyStimulus(3'b111, 1'b1, 1'b0);
    tickTo(270);
    checkOutput("shortGlitchRejected", {held, any_held}, 16'h0);
    tickTo(275);
    applyStimulus(3'b110, 1'b1, 1'b0);
    pushExp(275 + LAT, 3'b001, 3'b000);
    tickTo(280);
    applyStimulus(3'b111, 1'b1, 1'b0);
    pushExp(280 + LAT, 3'b000, 3'b001);
    tickTo(284);
    checkOutput("minimalPressHeld", {held, any_held}, 16'h3);

    tickTo(295);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL pendingPulse: expected pressed=%b released=%b at cycle %0d never seen",
               e.p, e.r, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
